// File: rtl/sramlike_axi_bridge_mp.sv
// Purpose: NUM_PORTS SRAM-like masters share one AXI3 master port. Round-robin arbitration,
//          up to RD_DEPTH in-order reads in flight, and one write (AW+W concurrent) at a time.
// Latency: addr_ok is asserted in the request cycle; AR/AW/W are valid the next cycle;
//          data_ok is asserted in the same cycle as the R or B handshake.
// Backpressure: a request waits (no addr_ok) while reads are full or blocked by a write,
//          while the AR slot is stalled, or while a write is pending or reads are still in flight.
// Ports: clk/rst (sync, active-high); per-port req/wr/size/addr/wdata in, addr_ok/data_ok out;
//        shared rdata out; full AXI3 AR/R/AW/W/B master channels.
module sramlike_axi_bridge_mp #(
    parameter int NUM_PORTS = 2,
    parameter int RD_DEPTH  = 4,
    parameter int ID_W      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS-1:0]    wr,
    input  logic [2*NUM_PORTS-1:0]  size,
    input  logic [32*NUM_PORTS-1:0] addr,
    input  logic [32*NUM_PORTS-1:0] wdata,
    output logic [31:0]             rdata,
    output logic [NUM_PORTS-1:0]    addr_ok,
    output logic [NUM_PORTS-1:0]    data_ok,
    output logic [ID_W-1:0]         arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic [1:0]              arlock,
    output logic [3:0]              arcache,
    output logic [2:0]              arprot,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_W-1:0]         rid,
    input  logic [31:0]             rdata_i,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_W-1:0]         awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_W-1:0]         wid,
    output logic [31:0]             wdata_o,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_W-1:0]         bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CW = $clog2(RD_DEPTH + 1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR_DATA, W_RESP} wst_t;

    // Responses carry no information the masters can act on, so IDs/resp/last are dropped.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

    // ---------------- state ----------------
    logic [PW-1:0]  rr_q;
    logic [CW-1:0]  rd_cnt_q, rd_cnt_d;
    logic [PW-1:0]  tag_q [RD_DEPTH];
    logic [TW-1:0]  wr_ptr_q, rd_ptr_q;

    logic           arvalid_q;
    logic [31:0]    araddr_q;
    logic [1:0]     arsize_q;
    logic [PW-1:0]  arid_q;

    wst_t           wst_q;
    logic           awvalid_q, wvalid_q;
    logic [31:0]    awaddr_q, wdata_q;
    logic [1:0]     awsize_q;
    logic [3:0]     wstrb_q;
    logic [PW-1:0]  wport_q;

    // ---------------- byte-lane strobes ----------------
    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] s;
        s = 4'b0000;
        case (sz)
            2'd0:    s = 4'b0001 << off;
            2'd1:    s = (off == 2'd0) ? 4'b0011 : ((off == 2'd2) ? 4'b1100 : 4'b0000);
            2'd2:    s = (off == 2'd0) ? 4'b1111 : 4'b0000;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // ---------------- arbitration ----------------
    logic                 rd_ok, wr_ok;
    logic [NUM_PORTS-1:0] elig;
    logic                 found;
    logic [PW-1:0]        win;
    int                   idx;
    logic                 acc_rd, acc_wr;
    logic [31:0]          sel_addr, sel_wdata;
    logic [1:0]           sel_size;

    // Reads need a free slot, no write pending, and an AR slot that is free or leaving.
    // The full test uses the registered count, so a same-cycle R beat does not free a slot.
    assign rd_ok = !rst && (rd_cnt_q < CW'(RD_DEPTH)) && (wst_q == W_IDLE) &&
                   (!arvalid_q || arready);
    // Writes wait for every read to drain, which keeps read/write order hazard-free.
    assign wr_ok = !rst && (wst_q == W_IDLE) && (rd_cnt_q == '0);

    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = req[i] && (wr[i] ? wr_ok : rd_ok);
        end
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_q) + k) % NUM_PORTS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    assign acc_rd    = found && !wr[win];
    assign acc_wr    = found && wr[win];
    assign addr_ok   = found ? (NUM_PORTS'(1) << win) : '0;
    assign sel_addr  = addr[32*win +: 32];
    assign sel_wdata = wdata[32*win +: 32];
    assign sel_size  = size[2*win +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= '0;
        end else if (found) begin
            rr_q <= (int'(win) == NUM_PORTS - 1) ? '0 : win + PW'(1);
        end
    end

    // ---------------- read path ----------------
    logic r_hs, b_hs;
    logic [PW-1:0] head;

    assign rready   = !rst && (rd_cnt_q != '0);
    assign r_hs     = rvalid && rready;
    assign head     = tag_q[rd_ptr_q];
    assign rdata    = rdata_i;
    assign rd_cnt_d = rd_cnt_q + CW'(acc_rd) - CW'(r_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            arid_q    <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            if (acc_rd) begin
                arvalid_q <= 1'b1;
                araddr_q  <= sel_addr;
                arsize_q  <= sel_size;
                arid_q    <= win;
                wr_ptr_q  <= (wr_ptr_q == TW'(RD_DEPTH - 1)) ? '0 : wr_ptr_q + TW'(1);
            end else if (arready) begin
                arvalid_q <= 1'b0;
            end
            if (r_hs) begin
                rd_ptr_q <= (rd_ptr_q == TW'(RD_DEPTH - 1)) ? '0 : rd_ptr_q + TW'(1);
            end
        end
    end

    // Tag storage holds data only; emptiness is tracked by rd_cnt_q.
    always_ff @(posedge clk) begin
        if (acc_rd) begin
            tag_q[wr_ptr_q] <= win;
        end
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wst_q     <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awsize_q  <= '0;
            wstrb_q   <= '0;
            wport_q   <= '0;
        end else begin
            case (wst_q)
                W_IDLE: begin
                    if (acc_wr) begin
                        wst_q     <= W_ADDR_DATA;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        awaddr_q  <= sel_addr;
                        wdata_q   <= sel_wdata;
                        awsize_q  <= sel_size;
                        wstrb_q   <= strb_of(sel_size, sel_addr[1:0]);
                        wport_q   <= win;
                    end
                end
                W_ADDR_DATA: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    // Both channels finished, in either order or together.
                    if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
                        wst_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bvalid) wst_q <= W_IDLE;
                end
                default: wst_q <= W_IDLE;
            endcase
        end
    end

    assign bready  = !rst && (wst_q == W_RESP);
    assign b_hs    = bvalid && bready;
    assign data_ok = (r_hs ? (NUM_PORTS'(1) << head) : '0) |
                     (b_hs ? (NUM_PORTS'(1) << wport_q) : '0);

    // ---------------- AXI outputs ----------------
    assign arid    = ID_W'(arid_q);
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, arsize_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;

    assign awid    = ID_W'(wport_q);
    assign awaddr  = awaddr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, awsize_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = awvalid_q;

    assign wid     = ID_W'(wport_q);
    assign wdata_o = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;

endmodule

// File: tb/tb_sramlike_axi_bridge_mp.sv
// Purpose: directed self-checking bench for sramlike_axi_bridge_mp (2 ports, 4 reads deep).
// Latency: inputs change just after each falling edge, outputs are sampled 1ns later.
// Backpressure: the AXI slave side is driven by hand from each scenario.
module tb_sramlike_axi_bridge_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, wr, addr_ok, data_ok;
    logic [3:0]  size;
    logic [63:0] addr, wdata;
    logic [31:0] rdata;
    logic [3:0]  arid, rid, awid, wid, bid;
    logic [31:0] araddr, rdata_i, awaddr, wdata_o;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sramlike_axi_bridge_mp #(.NUM_PORTS(2), .RD_DEPTH(4), .ID_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata_i(rdata_i), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata_o(wdata_o), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        req = '0; wr = '0; size = '0; addr = '0; wdata = '0;
        arready = 1'b0; rid = '0; rdata_i = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        req = 2'b01;
        #1;
        tests++; if (addr_ok !== 2'b00) begin fails++; $display("FAIL rst_addr_ok: got %b exp 00", addr_ok); end
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        #1;
        tests++; if (arvalid !== 1'b0) begin fails++; $display("FAIL rst_arvalid: got %b exp 0", arvalid); end
        tests++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin fails++; $display("FAIL rst_aw_w: got %b%b exp 00", awvalid, wvalid); end
        tests++; if (rready !== 1'b0 || bready !== 1'b0) begin fails++; $display("FAIL rst_rdy: got %b%b exp 00", rready, bready); end
        tests++; if (data_ok !== 2'b00) begin fails++; $display("FAIL rst_data_ok: got %b exp 00", data_ok); end
        tests++; if (dut.rd_cnt_q !== 3'd0) begin fails++; $display("FAIL rst_cnt: got %0d exp 0", dut.rd_cnt_q); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        req = 2'b01; wr = 2'b00; size = 4'b0010; addr[31:0] = 32'h1000; arready = 1'b1;
        #1;
        tests++; if (addr_ok !== 2'b01) begin fails++; $display("FAIL sr_addr_ok: got %b exp 01", addr_ok); end
        @(negedge clk);
        req = 2'b00;
        #1;
        tests++; if (arvalid !== 1'b1 || araddr !== 32'h1000) begin fails++; $display("FAIL sr_ar: got v=%b a=%h exp v=1 a=1000", arvalid, araddr); end
        tests++; if (arsize !== 3'd2 || arid !== 4'd0 || arlen !== 8'd0 || arburst !== 2'b01) begin fails++; $display("FAIL sr_ar_fields: got sz=%0d id=%0d len=%0d burst=%b exp 2 0 0 01", arsize, arid, arlen, arburst); end
        tests++; if (rready !== 1'b1) begin fails++; $display("FAIL sr_rready: got %b exp 1", rready); end
        repeat (2) @(negedge clk);
        rvalid = 1'b1; rdata_i = 32'hDEADBEEF;
        #1;
        tests++; if (data_ok !== 2'b01 || rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sr_data: got ok=%b d=%h exp 01 deadbeef", data_ok, rdata); end
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        tests++; if (data_ok !== 2'b00 || rready !== 1'b0 || arvalid !== 1'b0) begin fails++; $display("FAIL sr_idle: got ok=%b rr=%b av=%b exp 00 0 0", data_ok, rready, arvalid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ok;
        do_reset();
        arready = 1'b1;
        addr[31:0] = 32'h100; addr[63:32] = 32'h200; size = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req = 2'b11;
            #1;
            exp_ok = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (addr_ok !== exp_ok) begin fails++; $display("FAIL rr_order%0d: got %b exp %b", k, addr_ok, exp_ok); end
            if (k > 0) begin
                tests++; if (arid !== ((k % 2 == 1) ? 4'd0 : 4'd1)) begin fails++; $display("FAIL rr_arid%0d: got %0d exp %0d", k, arid, (k % 2 == 1) ? 0 : 1); end
            end
        end
        @(negedge clk);
        req = 2'b00;
        #1;
        tests++; if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h200) begin fails++; $display("FAIL rr_last_ar: got v=%b id=%0d a=%h exp 1 1 200", arvalid, arid, araddr); end
        tests++; if (dut.rd_cnt_q !== 3'd4) begin fails++; $display("FAIL rr_cnt: got %0d exp 4", dut.rd_cnt_q); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata_i = 32'hA0 + k;
            #1;
            exp_ok = (k % 2 == 0) ? 2'b01 : 2'b10;
            tests++; if (data_ok !== exp_ok || rdata !== 32'hA0 + k) begin fails++; $display("FAIL rr_ret%0d: got ok=%b d=%h exp %b %h", k, data_ok, rdata, exp_ok, 32'hA0 + k); end
        end
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        tests++; if (rready !== 1'b0) begin fails++; $display("FAIL rr_drained: got rready=%b exp 0", rready); end
    endtask

    task automatic test_depth_limit();
        int n_ok;
        do_reset();
        arready = 1'b1; size = 4'b0010; addr[31:0] = 32'h3000;
        n_ok = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            req = 2'b01;
            #1;
            if (addr_ok == 2'b01) n_ok++;
        end
        tests++; if (n_ok !== 4) begin fails++; $display("FAIL dl_accepts: got %0d exp 4", n_ok); end
        tests++; if (dut.rd_cnt_q !== 3'd4) begin fails++; $display("FAIL dl_cnt: got %0d exp 4", dut.rd_cnt_q); end
        @(negedge clk);
        rvalid = 1'b1; rdata_i = 32'h11;
        #1;
        tests++; if (addr_ok !== 2'b00 || data_ok !== 2'b01) begin fails++; $display("FAIL dl_full_beat: got aok=%b dok=%b exp 00 01", addr_ok, data_ok); end
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        tests++; if (addr_ok !== 2'b01) begin fails++; $display("FAIL dl_fifth: got %b exp 01", addr_ok); end
        @(negedge clk);
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            rvalid = 1'b1;
            #1;
            tests++; if (data_ok !== 2'b01) begin fails++; $display("FAIL dl_drain%0d: got %b exp 01", k, data_ok); end
        end
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        tests++; if (dut.rd_cnt_q !== 3'd0) begin fails++; $display("FAIL dl_cnt_end: got %0d exp 0", dut.rd_cnt_q); end
    endtask

    task automatic test_write_ordering();
        do_reset();
        arready = 1'b1; size = 4'b0010; addr[31:0] = 32'h10;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req = 2'b01;
            #1;
            tests++; if (addr_ok !== 2'b01) begin fails++; $display("FAIL wo_read%0d: got %b exp 01", k, addr_ok); end
        end
        @(negedge clk);
        req = 2'b10; wr = 2'b10; size = 4'b0010; addr[63:32] = 32'h2003; wdata[63:32] = 32'h5500_0000;
        #1;
        tests++; if (addr_ok !== 2'b00) begin fails++; $display("FAIL wo_block0: got %b exp 00", addr_ok); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rvalid = 1'b1; rdata_i = 32'h1 + k;
            #1;
            tests++; if (addr_ok !== 2'b00 || data_ok !== 2'b01) begin fails++; $display("FAIL wo_beat%0d: got aok=%b dok=%b exp 00 01", k, addr_ok, data_ok); end
        end
        @(negedge clk);
        rvalid = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        tests++; if (addr_ok !== 2'b10) begin fails++; $display("FAIL wo_accept: got %b exp 10", addr_ok); end
        @(negedge clk);
        req = 2'b00; wr = 2'b00;
        #1;
        tests++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin fails++; $display("FAIL wo_valids: got %b%b exp 11", awvalid, wvalid); end
        tests++; if (awaddr !== 32'h2003 || wstrb !== 4'b1000 || awsize !== 3'd0) begin fails++; $display("FAIL wo_aw: got a=%h s=%b sz=%0d exp 2003 1000 0", awaddr, wstrb, awsize); end
        tests++; if (awid !== 4'd1 || wid !== 4'd1 || wlast !== 1'b1 || wdata_o !== 32'h5500_0000) begin fails++; $display("FAIL wo_w: got id=%0d wid=%0d last=%b d=%h exp 1 1 1 55000000", awid, wid, wlast, wdata_o); end
        @(negedge clk);
        bvalid = 1'b1;
        #1;
        tests++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b1) begin fails++; $display("FAIL wo_resp_state: got av=%b wv=%b br=%b exp 0 0 1", awvalid, wvalid, bready); end
        tests++; if (data_ok !== 2'b10) begin fails++; $display("FAIL wo_data_ok: got %b exp 10", data_ok); end
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        tests++; if (bready !== 1'b0 || data_ok !== 2'b00) begin fails++; $display("FAIL wo_done: got br=%b dok=%b exp 0 00", bready, data_ok); end
    endtask

    task automatic test_wstrb();
        logic [1:0] sz_t   [5];
        logic [1:0] off_t  [5];
        logic [3:0] strb_t [5];
        sz_t = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        off_t = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
        strb_t = '{4'b0010, 4'b1100, 4'b0000, 4'b0000, 4'b0100};
        do_reset();
        awready = 1'b1; wready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req = 2'b01; wr = 2'b01; size = {2'b00, sz_t[k]}; addr[31:0] = {30'h1400, off_t[k]};
            #1;
            tests++; if (addr_ok !== 2'b01) begin fails++; $display("FAIL ws_accept%0d: got %b exp 01", k, addr_ok); end
            @(negedge clk);
            req = 2'b00; wr = 2'b00;
            #1;
            tests++; if (wstrb !== strb_t[k] || awvalid !== 1'b1) begin fails++; $display("FAIL ws_strb%0d: got s=%b av=%b exp %b 1", k, wstrb, awvalid, strb_t[k]); end
            @(negedge clk);
            bvalid = 1'b1;
            #1;
            tests++; if (data_ok !== 2'b01) begin fails++; $display("FAIL ws_bresp%0d: got %b exp 01", k, data_ok); end
            @(negedge clk);
            bvalid = 1'b0;
        end
    endtask

    task automatic test_aw_w_skew();
        do_reset();
        wready = 1'b1; awready = 1'b0;
        @(negedge clk);
        req = 2'b10; wr = 2'b10; size = 4'b1010; addr[63:32] = 32'h3000; wdata[63:32] = 32'h1234_5678;
        addr[31:0] = 32'h40;
        #1;
        tests++; if (addr_ok !== 2'b10) begin fails++; $display("FAIL sk_accept: got %b exp 10", addr_ok); end
        @(negedge clk);
        req = 2'b01; wr = 2'b00;
        #1;
        tests++; if (awvalid !== 1'b1 || wvalid !== 1'b1 || wstrb !== 4'b1111 || addr_ok !== 2'b00) begin fails++; $display("FAIL sk_issue: got av=%b wv=%b s=%b aok=%b exp 1 1 1111 00", awvalid, wvalid, wstrb, addr_ok); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            tests++; if (wvalid !== 1'b0 || awvalid !== 1'b1 || bready !== 1'b0 || addr_ok !== 2'b00) begin fails++; $display("FAIL sk_hold%0d: got wv=%b av=%b br=%b aok=%b exp 0 1 0 00", k, wvalid, awvalid, bready, addr_ok); end
        end
        @(negedge clk);
        awready = 1'b1;
        #1;
        tests++; if (awvalid !== 1'b1 || bready !== 1'b0) begin fails++; $display("FAIL sk_aw_hs: got av=%b br=%b exp 1 0", awvalid, bready); end
        @(negedge clk);
        awready = 1'b0;
        #1;
        tests++; if (awvalid !== 1'b0 || bready !== 1'b1 || addr_ok !== 2'b00) begin fails++; $display("FAIL sk_resp: got av=%b br=%b aok=%b exp 0 1 00", awvalid, bready, addr_ok); end
        @(negedge clk);
        bvalid = 1'b1;
        #1;
        tests++; if (data_ok !== 2'b10 || addr_ok !== 2'b00) begin fails++; $display("FAIL sk_b: got dok=%b aok=%b exp 10 00", data_ok, addr_ok); end
        @(negedge clk);
        bvalid = 1'b0; arready = 1'b1;
        #1;
        tests++; if (addr_ok !== 2'b01) begin fails++; $display("FAIL sk_read_after: got %b exp 01", addr_ok); end
        @(negedge clk);
        req = 2'b00;
        #1;
        tests++; if (arvalid !== 1'b1 || araddr !== 32'h40) begin fails++; $display("FAIL sk_ar: got v=%b a=%h exp 1 40", arvalid, araddr); end
        @(negedge clk);
        rvalid = 1'b1; rdata_i = 32'h77;
        #1;
        tests++; if (data_ok !== 2'b01) begin fails++; $display("FAIL sk_rdata: got %b exp 01", data_ok); end
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        arready = 1'b1; size = 4'b0110; addr[31:0] = 32'h50; addr[63:32] = 32'h4000;
        repeat (2) begin
            @(negedge clk);
            req = 2'b01;
        end
        @(negedge clk);
        req = 2'b00; rst = 1'b1;
        #1;
        tests++; if (rready !== 1'b0) begin fails++; $display("FAIL rm_rready_in_rst: got %b exp 0", rready); end
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata_i = 32'hBAD0_BAD0;
        #1;
        tests++; if (arvalid !== 1'b0 || rready !== 1'b0 || data_ok !== 2'b00) begin fails++; $display("FAIL rm_after: got av=%b rr=%b dok=%b exp 0 0 00", arvalid, rready, data_ok); end
        tests++; if (dut.rd_cnt_q !== 3'd0) begin fails++; $display("FAIL rm_cnt: got %0d exp 0", dut.rd_cnt_q); end
        @(negedge clk);
        rvalid = 1'b0; req = 2'b10; wr = 2'b00;
        #1;
        tests++; if (addr_ok !== 2'b10) begin fails++; $display("FAIL rm_fresh_accept: got %b exp 10", addr_ok); end
        @(negedge clk);
        req = 2'b00;
        #1;
        tests++; if (arid !== 4'd1 || araddr !== 32'h4000 || arsize !== 3'd1) begin fails++; $display("FAIL rm_fresh_ar: got id=%0d a=%h sz=%0d exp 1 4000 1", arid, araddr, arsize); end
        @(negedge clk);
        rvalid = 1'b1; rdata_i = 32'hCAFE_0000;
        #1;
        tests++; if (data_ok !== 2'b10 || rdata !== 32'hCAFE_0000) begin fails++; $display("FAIL rm_fresh_data: got ok=%b d=%h exp 10 cafe0000", data_ok, rdata); end
        @(negedge clk);
        rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_depth_limit();
        test_write_ordering();
        test_wstrb();
        test_aw_w_skew();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
